// File: rtl/imem_responder.sv
// Instruction-fetch responder: on-chip instruction memory behind a valid/ready request port,
// a fixed-latency read pipeline, an in-order output queue and credit-based request throttling.
module imem_responder #(
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic [31:0]        mem [DEPTH];
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_err;
  logic [31:0]        pipe_data [LATENCY];
  logic [31:0]        q_data [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] q_err;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      q_count;
  logic [CW-1:0]      outstanding;

  logic          accept;
  logic          push;
  logic          pop;
  logic          req_bad;
  logic          ld_in_range;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] ld_idx;
  logic          unused_ld_bits;

  assign unused_ld_bits = ^ld_addr[1:0];

  assign req_idx     = req_addr[AW+1:2];
  assign ld_idx      = ld_addr[AW+1:2];
  assign req_bad     = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign ld_in_range = (ld_addr[31:AW+2] == '0);

  // Credits cover both the read pipeline and the queue, so a push can never find the queue full.
  assign req_ready = (outstanding < CW'(OUT_DEPTH));
  assign accept    = req_valid && req_ready;
  assign push      = pipe_valid[LATENCY-1];
  assign rsp_valid = (q_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  assign rsp_data = rsp_valid ? q_data[rd_ptr] : '0;
  assign rsp_err  = rsp_valid && q_err[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Datapath storage needs no reset; its validity is tracked by the reset-domain flags below.
  // The nonblocking memory write means a same-edge fetch of the same word sees the old value.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem[ld_idx] <= ld_data;
    end
    pipe_data[0] <= req_bad ? '0 : mem[req_idx];
    pipe_err[0]  <= req_bad;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_err[i]  <= pipe_err[i-1];
    end
    if (push) begin
      q_data[wr_ptr] <= pipe_data[LATENCY-1];
      q_err[wr_ptr]  <= pipe_err[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      outstanding <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        q_count <= q_count + 1'b1;
      end else if (!push && pop) begin
        q_count <= q_count - 1'b1;
      end
      if (accept && !pop) begin
        outstanding <= outstanding + 1'b1;
      end else if (!accept && pop) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus a random soak, all checked by
// a scoreboard monitor against a word-array reference model with per-request eligibility times.
module tb_imem_responder;

  localparam int DEPTH     = 64;
  localparam int LATENCY   = 2;
  localparam int OUT_DEPTH = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          elig;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        new_exp;
  logic [31:0] model_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_count = 0;
  int          acc_start;
  bit          exp_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] a, input bit r,
                               input bit le, input logic [31:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    rsp_ready = r;
    ld_en     = le;
    ld_addr   = la;
    ld_data   = ld;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, r, 1'b0, 32'h0, 32'h0);
  endtask

  // Inputs settle 1ns after the rising edge, so the falling edge sees exactly what the next
  // rising edge will act on; the model advances here, fetch before load for same-edge ordering.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      checkOutput("req_ready", req_ready, (exp_q.size() < OUT_DEPTH));
      exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].elig);
      checkOutput("rsp_valid", rsp_valid, exp_valid);
      if (rsp_valid && exp_valid) begin
        checkOutput("rsp_data", rsp_data, exp_q[0].data);
        checkOutput("rsp_err", rsp_err, exp_q[0].err);
        if (rsp_ready) void'(exp_q.pop_front());
      end
      if (req_valid && req_ready) begin
        new_exp.err  = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
        new_exp.data = new_exp.err ? 32'h0 : model_mem[req_addr / 4];
        new_exp.elig = cyc + 1 + LATENCY;
        exp_q.push_back(new_exp);
        acc_count++;
      end
      if (ld_en && (ld_addr / 4 < DEPTH)) model_mem[ld_addr / 4] = ld_data;
    end
  end

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
    if (sel == 1) return (DEPTH * 4) + ($urandom_range(0, 255) * 4);
    return $urandom_range(0, DEPTH - 1) * 4;
  endfunction

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_data", rsp_data, 32'h0);
    checkOutput("reset_rsp_err", rsp_err, 1'b0);
    checkOutput("reset_req_ready", req_ready, 1'b1);

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, i * 4, $urandom);

    $display("[TB] in-order back-to-back fetch");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h11111111);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h22222222);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h33333333);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(LATENCY + 3, 1'b1);

    $display("[TB] back-pressure credit limit");
    acc_start = acc_count;
    for (int i = 0; i < OUT_DEPTH + 3; i++) applyStimulus(1'b1, i * 4, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    checkOutput("credit_accepts", acc_count - acc_start, OUT_DEPTH);
    checkOutput("credit_req_ready_low", req_ready, 1'b0);
    idle(OUT_DEPTH + 2, 1'b1);
    @(negedge clk); #1;
    checkOutput("credit_req_ready_back", req_ready, 1'b1);

    $display("[TB] error responses");
    applyStimulus(1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, DEPTH * 4, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(LATENCY + 3, 1'b1);

    $display("[TB] load/fetch collision");
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b1, 32'h4, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(LATENCY + 3, 1'b1);

    $display("[TB] mid-operation reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, i * 4, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("flush_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("flush_req_ready", req_ready, 1'b1);
    idle(LATENCY + 6, 1'b1);

    $display("[TB] random soak");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 60), rand_addr(), ($urandom_range(0, 99) < 55),
                    ($urandom_range(0, 99) < 10), rand_addr() & ~32'h3, $urandom);
    end
    idle(OUT_DEPTH + LATENCY + 10, 1'b1);
    @(negedge clk); #1;
    checkOutput("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
